// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer: sequencer state codes and
// block/word geometry.
package sha256_pkg;

   localparam int unsigned SHA256_WORDS_PER_BLOCK = 16;
   localparam int unsigned SHA256_WORD_W          = 32;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      NEWMSG    = 3'd1,
      LOAD      = 3'd2,
      WAIT_DONE = 3'd3,
      DIGEST    = 3'd4
   } seq_state_e;

endpackage

// File: rtl/sha256_block_sequencer.sv
// Feeds a valid/ready word stream into the SHA-256 core one 512-bit block at a time,
// chaining blocks of a message. SHA_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog.
module sha256_block_sequencer
   import sha256_pkg::*;
#(
   parameter int unsigned WORDS_PER_BLOCK = SHA256_WORDS_PER_BLOCK,
   parameter int unsigned BLK_CNT_W       = 16
`ifdef SHA_SEQ_TIMEOUT_EN
   , parameter int unsigned DONE_TIMEOUT  = 1023
`endif
) (
   input  logic                     iClk,
   input  logic                     iReset_n,
   input  logic                     iMsg_valid,
   output logic                     oMsg_ready,
   input  logic [SHA256_WORD_W-1:0] iMsg_data,
   input  logic                     iMsg_last,
   input  logic                     iAbort,
   output logic                     oCore_start,
   output logic                     oCore_data_valid,
   output logic [SHA256_WORD_W-1:0] oCore_data,
   output logic                     oCore_new_input_n,
   input  logic                     iCore_done,
   output logic                     oBusy,
   output logic                     oDigest_valid,
   output logic [BLK_CNT_W-1:0]     oBlock_count,
   output logic                     oTimeout
);

   localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

   seq_state_e                state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      last_blk_q, last_blk_d;
   logic [SHA256_WORD_W-1:0]  data_q, data_d;
   logic                      strobe_q, strobe_d;
   logic                      new_input_n_q, new_input_n_d;
   logic                      digest_q, digest_d;
   logic [BLK_CNT_W-1:0]      blk_cnt_q, blk_cnt_d;
   logic                      done_q;
   logic                      accept, done_rise, wdog_expire;

   // Ready is dropped combinationally under abort so a same-cycle word is never taken.
   assign oMsg_ready = (state_q == LOAD) && !iAbort;
   assign oBusy      = (state_q != IDLE);
   assign accept     = iMsg_valid && oMsg_ready;
   assign done_rise  = iCore_done && !done_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_blk_d = last_blk_q;
      data_d     = data_q;
      strobe_d   = 1'b0;
      blk_cnt_d  = blk_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (iMsg_valid) state_d = NEWMSG;
         end
         NEWMSG: begin
            blk_cnt_d = '0;
            state_d   = LOAD;
         end
         LOAD: begin
            if (accept) begin
               data_d   = iMsg_data;
               strobe_d = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d      = '0;
                  last_blk_d = iMsg_last;
                  state_d    = WAIT_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         WAIT_DONE: begin
            if (done_rise) begin
               if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
               state_d = last_blk_q ? DIGEST : LOAD;
            end
         end
         DIGEST: begin
            last_blk_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort and watchdog expiry drop the message; the block count is kept for software.
      if ((iAbort && (state_q != IDLE)) || wdog_expire) begin
         state_d    = IDLE;
         idx_d      = '0;
         last_blk_d = 1'b0;
      end
      new_input_n_d = (state_d != NEWMSG);
      digest_d      = (state_d == DIGEST);
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         last_blk_q    <= 1'b0;
         data_q        <= '0;
         strobe_q      <= 1'b0;
         new_input_n_q <= 1'b1;
         digest_q      <= 1'b0;
         blk_cnt_q     <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         last_blk_q    <= last_blk_d;
         data_q        <= data_d;
         strobe_q      <= strobe_d;
         new_input_n_q <= new_input_n_d;
         digest_q      <= digest_d;
         blk_cnt_q     <= blk_cnt_d;
         done_q        <= iCore_done;
      end
   end

   assign oCore_start       = strobe_q;
   assign oCore_data_valid  = strobe_q;
   assign oCore_data        = data_q;
   assign oCore_new_input_n = new_input_n_q;
   assign oDigest_valid     = digest_q;
   assign oBlock_count      = blk_cnt_q;

`ifdef SHA_SEQ_TIMEOUT_EN
   localparam int unsigned WDOG_W = $clog2(DONE_TIMEOUT + 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timeout_q, timeout_d;

   // Counter restarts from zero on every entry into WAIT_DONE.
   always_comb begin
      wdog_d    = '0;
      timeout_d = timeout_q;
      if (state_q == WAIT_DONE) wdog_d = wdog_q + WDOG_W'(1);
      if (state_q == NEWMSG) timeout_d = 1'b0;
      if (wdog_expire) timeout_d = 1'b1;
   end

   assign wdog_expire = (state_q == WAIT_DONE) && !done_rise &&
                        (wdog_q == WDOG_W'(DONE_TIMEOUT - 1));

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign oTimeout = timeout_q;
`else
   assign wdog_expire = 1'b0;
   assign oTimeout    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: accepted words are queued and matched
// against core strobes; pulse counters check new-input, digest and block counts.
`timescale 1ns/1ps
module tb_sha256_block_sequencer;

   logic        clk = 1'b0;
   logic        iReset_n = 1'b0;
   logic        iMsg_valid = 1'b0;
   logic        oMsg_ready;
   logic [31:0] iMsg_data = '0;
   logic        iMsg_last = 1'b0;
   logic        iAbort = 1'b0;
   logic        oCore_start;
   logic        oCore_data_valid;
   logic [31:0] oCore_data;
   logic        oCore_new_input_n;
   logic        iCore_done = 1'b0;
   logic        oBusy;
   logic        oDigest_valid;
   logic [15:0] oBlock_count;
   logic        oTimeout;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   logic [31:0] exp_q[$];
   int          strobes = 0, new_pulses = 0, new_low = 0, digests = 0;
   int          s0, p0, l0, d0;

   always #5 clk = ~clk;

`ifdef SHA_SEQ_TIMEOUT_EN
   sha256_block_sequencer #(.DONE_TIMEOUT(8)) dut (
      .iClk(clk), .iReset_n(iReset_n),
      .iMsg_valid(iMsg_valid), .oMsg_ready(oMsg_ready),
      .iMsg_data(iMsg_data), .iMsg_last(iMsg_last), .iAbort(iAbort),
      .oCore_start(oCore_start), .oCore_data_valid(oCore_data_valid),
      .oCore_data(oCore_data), .oCore_new_input_n(oCore_new_input_n),
      .iCore_done(iCore_done), .oBusy(oBusy), .oDigest_valid(oDigest_valid),
      .oBlock_count(oBlock_count), .oTimeout(oTimeout)
   );
`else
   sha256_block_sequencer dut (
      .iClk(clk), .iReset_n(iReset_n),
      .iMsg_valid(iMsg_valid), .oMsg_ready(oMsg_ready),
      .iMsg_data(iMsg_data), .iMsg_last(iMsg_last), .iAbort(iAbort),
      .oCore_start(oCore_start), .oCore_data_valid(oCore_data_valid),
      .oCore_data(oCore_data), .oCore_new_input_n(oCore_new_input_n),
      .iCore_done(iCore_done), .oBusy(oBusy), .oDigest_valid(oDigest_valid),
      .oBlock_count(oBlock_count), .oTimeout(oTimeout)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: sample the handshake just before each edge, check core outputs just after it.
   initial begin
      logic acc;
      logic prev_n;
      prev_n = 1'b1;
      forever begin
         @(negedge clk); #4;
         acc = iReset_n && iMsg_valid && oMsg_ready;
         if (acc) exp_q.push_back(iMsg_data);
         @(posedge clk); #1;
         check("strobe_latency", 32'(oCore_data_valid), 32'(acc));
         check("start_eq_valid", 32'(oCore_start), 32'(oCore_data_valid));
         if (oCore_data_valid) begin
            strobes++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("core_data", oCore_data, exp_q.pop_front());
         end
         if (!oCore_new_input_n) begin
            new_low++;
            if (prev_n) new_pulses++;
         end
         prev_n = oCore_new_input_n;
         if (oDigest_valid) digests++;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

   function automatic logic [31:0] pad_word(input int i);
      if (i == 0) return 32'h6162_6380;
      if (i == 15) return 32'h0000_0018;
      return 32'h0;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; holds the word until the sequencer takes it.
   task automatic send_word(input logic [31:0] d, input logic l);
      logic took;
      took = 1'b0;
      iMsg_valid = 1'b1; iMsg_data = d; iMsg_last = l;
      for (int i = 0; i < 50 && !took; i++) begin
         #4;
         took = oMsg_ready;
         @(negedge clk);
      end
      iMsg_valid = 1'b0; iMsg_last = 1'b0;
      check("word_accepted", 32'(took), 32'd1);
   endtask

   task automatic send_block(input logic [31:0] base, input logic last, input int gap);
      for (int i = 0; i < 16; i++) begin
         send_word(base + 32'(i), last && (i == 15));
         idle(gap);
      end
   endtask

   task automatic pulse_done();
      iCore_done = 1'b1;
      @(negedge clk);
      iCore_done = 1'b0;
   endtask

   task automatic snap();
      s0 = strobes; p0 = new_pulses; l0 = new_low; d0 = digests;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(oMsg_ready), 32'd0);
      check({tag, "_start"}, 32'(oCore_start), 32'd0);
      check({tag, "_dvalid"}, 32'(oCore_data_valid), 32'd0);
      check({tag, "_data"}, oCore_data, 32'd0);
      check({tag, "_newin_n"}, 32'(oCore_new_input_n), 32'd1);
      check({tag, "_digest"}, 32'(oDigest_valid), 32'd0);
      check({tag, "_busy"}, 32'(oBusy), 32'd0);
      check({tag, "_blkcnt"}, 32'(oBlock_count), 32'd0);
      check({tag, "_timeout"}, 32'(oTimeout), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      iReset_n = 1'b1;
      idle(2);

      // Single padded block
      snap();
      for (int i = 0; i < 16; i++) send_word(pad_word(i), i == 15);
      idle(3);
      check("t1_wait_ready", 32'(oMsg_ready), 32'd0);
      check("t1_wait_busy", 32'(oBusy), 32'd1);
      check("t1_wait_blkcnt", 32'(oBlock_count), 32'd0);
      pulse_done();
      idle(3);
      check("t1_strobes", 32'(strobes - s0), 32'd16);
      check("t1_newin_pulses", 32'(new_pulses - p0), 32'd1);
      check("t1_newin_low_cycles", 32'(new_low - l0), 32'd1);
      check("t1_digests", 32'(digests - d0), 32'd1);
      check("t1_blkcnt", 32'(oBlock_count), 32'd1);
      check("t1_busy", 32'(oBusy), 32'd0);

      // Two-block message; a stray last on word 3 must be ignored
      snap();
      for (int i = 0; i < 16; i++) send_word(32'h1000 + 32'(i), i == 3);
      idle(3);
      check("t2_wait_ready", 32'(oMsg_ready), 32'd0);
      check("t2_blkcnt_cleared", 32'(oBlock_count), 32'd0);
      check("t2_no_early_digest", 32'(digests - d0), 32'd0);
      pulse_done();
      idle(1);
      check("t2_blkcnt_mid", 32'(oBlock_count), 32'd1);
      check("t2_ready_resumed", 32'(oMsg_ready), 32'd1);
      send_block(32'h2000, 1'b1, 0);
      idle(2);
      pulse_done();
      idle(3);
      check("t2_strobes", 32'(strobes - s0), 32'd32);
      check("t2_newin_pulses", 32'(new_pulses - p0), 32'd1);
      check("t2_digests", 32'(digests - d0), 32'd1);
      check("t2_blkcnt", 32'(oBlock_count), 32'd2);

      // Bubbles between every word
      snap();
      send_block(32'hA5A5_0000, 1'b1, 1);
      idle(2);
      pulse_done();
      idle(3);
      check("t3_strobes", 32'(strobes - s0), 32'd16);
      check("t3_digests", 32'(digests - d0), 32'd1);

      // Abort while presenting word 7
      snap();
      for (int i = 0; i < 7; i++) send_word(32'h3000 + 32'(i), 1'b0);
      iMsg_valid = 1'b1; iMsg_data = 32'h3007; iAbort = 1'b1;
      #4;
      check("t4_ready_under_abort", 32'(oMsg_ready), 32'd0);
      @(negedge clk);
      iAbort = 1'b0; iMsg_valid = 1'b0;
      check("t4_idle_after_abort", 32'(oBusy), 32'd0);
      idle(3);
      check("t4_strobes", 32'(strobes - s0), 32'd7);
      check("t4_no_digest", 32'(digests - d0), 32'd0);
      send_block(32'h4000, 1'b1, 0);
      idle(2);
      pulse_done();
      idle(3);
      check("t4_newin_pulses", 32'(new_pulses - p0), 32'd2);
      check("t4_digests", 32'(digests - d0), 32'd1);
      check("t4_blkcnt", 32'(oBlock_count), 32'd1);

      // Done already high (raised during LOAD) must not advance WAIT_DONE
      snap();
      for (int i = 0; i < 16; i++) begin
         if (i == 10) iCore_done = 1'b1;
         send_word(32'h5000 + 32'(i), i == 15);
      end
      idle(4);
      check("t5_held_busy", 32'(oBusy), 32'd1);
      check("t5_held_blkcnt", 32'(oBlock_count), 32'd0);
      check("t5_held_digest", 32'(digests - d0), 32'd0);
      iCore_done = 1'b0;
      idle(2);
      check("t5_low_busy", 32'(oBusy), 32'd1);
      iCore_done = 1'b1;
      idle(3);
      iCore_done = 1'b0;
      check("t5_digests", 32'(digests - d0), 32'd1);
      check("t5_blkcnt", 32'(oBlock_count), 32'd1);
      idle(2);

      // Reset while presenting word 5
      for (int i = 0; i < 5; i++) send_word(32'h6000 + 32'(i), 1'b0);
      iMsg_valid = 1'b1; iMsg_data = 32'h6005; iReset_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      iReset_n = 1'b1; iMsg_valid = 1'b0;
      idle(2);
      snap();
      send_block(32'h7000, 1'b1, 0);
      idle(2);
      pulse_done();
      idle(3);
      check("t6_strobes", 32'(strobes - s0), 32'd16);
      check("t6_digests", 32'(digests - d0), 32'd1);
      check("t6_blkcnt", 32'(oBlock_count), 32'd1);

`ifdef SHA_SEQ_TIMEOUT_EN
      // Done never arrives: watchdog returns to IDLE with the sticky flag set
      snap();
      send_block(32'h8000, 1'b1, 0);
      idle(12);
      check("t7_timeout", 32'(oTimeout), 32'd1);
      check("t7_busy", 32'(oBusy), 32'd0);
      check("t7_no_digest", 32'(digests - d0), 32'd0);
`else
      check("t7_timeout_tied", 32'(oTimeout), 32'd0);
`endif
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
